mod_cache_arbiter: RTL and testbench

MOD_CACHE_ARBITER -- requirements
Module: mod_cache_arbiter

---
 rtl/mod_cache_arbiter_pkg.sv | 24 ++
 rtl/mod_cache_arbiter_if.sv | 39 +++
 rtl/mod_cache_arbiter_rr.sv | 30 +++
 rtl/mod_cache_arbiter.sv | 103 ++++++++++
 tb/tb_mod_cache_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_cache_arbiter_pkg.sv
// Shared types and constants for the two-port cache fill arbiter.
// The state encoding, default beat count and tag type live here.
package cache_arb_pkg;

  localparam int unsigned BUS_WIDTH_DEF  = 64;
  localparam int unsigned BLOCK_BITS_DEF = 512;
  localparam int unsigned TAG_WIDTH_DEF  = 13;
  localparam int unsigned BEATS          = BLOCK_BITS_DEF / BUS_WIDTH_DEF;

  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS_REQ,
    S_COLLECT,
    S_DELIVER
  } state_t;

  // Fills are whole 64-byte blocks, so the byte offset is cleared.
  function automatic logic [63:0] block_align(input logic [63:0] addr);
    return {addr[63:6], 6'b0};
  endfunction

endpackage

// File: rtl/mod_cache_arbiter_if.sv
// Upstream cache ports and system-bus handshake bundle for mod_cache_arbiter.
// slave = arbiter side, master = caches/bus side.
interface mod_cache_arbiter_if #(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned BLOCK_BITS = 512,
  parameter int unsigned TAG_WIDTH  = 13
);
  logic [1:0]                 up_reqcyc;
  logic [1:0]                 up_reqack;
  logic [1:0][63:0]           up_req;
  logic [1:0][TAG_WIDTH-1:0]  up_reqtag;
  logic [1:0]                 up_respcyc;
  logic [1:0]                 up_respack;
  logic [BLOCK_BITS-1:0]      up_resp;
  logic [TAG_WIDTH-1:0]       up_resptag;

  logic                       bus_reqcyc;
  logic                       bus_reqack;
  logic [63:0]                bus_req;
  logic [TAG_WIDTH-1:0]       bus_reqtag;
  logic                       bus_respcyc;
  logic                       bus_respack;
  logic [BUS_WIDTH-1:0]       bus_resp;
  logic [TAG_WIDTH-1:0]       bus_resptag;

  modport slave (
    input  up_reqcyc, up_req, up_reqtag, up_respack,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output up_reqack, up_respcyc, up_resp, up_resptag,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output up_reqcyc, up_req, up_reqtag, up_respack,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  up_reqack, up_respcyc, up_resp, up_resptag,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/mod_cache_arbiter_rr.sv
// Two-way grant selection. CACHE_ARB_ROUND_ROBIN_EN: alternate on contention;
// otherwise port 1 (D-cache) has fixed priority.
module mod_rr_arbiter2 (
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic       grant
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    grant = req[1];
    if (&req) grant = ptr;
  end

  // Loser of the latest grant gets priority next time both contend.
  always_ff @(posedge clk) begin
    if (reset)     ptr <= 1'b0;
    else if (take) ptr <= ~grant;
  end
`else
  assign grant = req[1];
`endif

endmodule

// File: rtl/mod_cache_arbiter.sv
// Arbitrates I-/D-cache block fills onto one system bus and assembles beats.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN selects round-robin contention.
module mod_cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned BLOCK_BITS = 512,
  parameter int unsigned TAG_WIDTH  = 13
) (
  input logic                 clk,
  input logic                 reset,
  mod_cache_arbiter_if.slave  arb
);

  localparam int unsigned NBEATS = BLOCK_BITS / BUS_WIDTH;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t               state;
  logic [BEAT_W-1:0]    beat;
  logic                 grant;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 win;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic take;
  assign take = (state == S_IDLE) && (|arb.up_reqcyc);

  mod_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .take  (take),
    .req   (arb.up_reqcyc),
    .grant (win)
  );
`else
  mod_rr_arbiter2 u_arb (
    .req   (arb.up_reqcyc),
    .grant (win)
  );
`endif

  assign arb.bus_respack = arb.bus_respcyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      beat           <= '0;
      grant          <= 1'b0;
      tag_q          <= '0;
      arb.up_reqack  <= '0;
      arb.up_respcyc <= '0;
      arb.up_resp    <= '0;
      arb.up_resptag <= '0;
      arb.bus_reqcyc <= 1'b0;
      arb.bus_req    <= '0;
      arb.bus_reqtag <= '0;
    end else begin
      arb.up_reqack <= '0;
      case (state)
        S_IDLE: begin
          if (|arb.up_reqcyc) begin
            arb.up_reqack[win] <= 1'b1;
            grant              <= win;
            tag_q              <= arb.up_reqtag[win];
            arb.bus_reqcyc     <= 1'b1;
            arb.bus_req        <= block_align(arb.up_req[win]);
            arb.bus_reqtag     <= arb.up_reqtag[win];
            state              <= S_BUS_REQ;
          end
        end
        S_BUS_REQ: begin
          if (arb.bus_reqack) begin
            arb.bus_reqcyc <= 1'b0;
            beat           <= '0;
            state          <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (arb.bus_respcyc) begin
            arb.up_resp[int'(beat)*BUS_WIDTH +: BUS_WIDTH] <= arb.bus_resp;
            if (beat == LAST_BEAT) begin
              beat                  <= '0;
              arb.up_respcyc[grant] <= 1'b1;
              arb.up_resptag        <= tag_q;
              state                 <= S_DELIVER;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_DELIVER: begin
          if (arb.up_respack[grant]) begin
            arb.up_respcyc <= '0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Directed self-checking bench for mod_cache_arbiter; inputs driven and
// outputs sampled on the falling clock edge.
module tb_mod_cache_arbiter;
  import cache_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_cache_arbiter_if #(.BUS_WIDTH(64), .BLOCK_BITS(512), .TAG_WIDTH(13)) bus_if ();

  mod_cache_arbiter #(.BUS_WIDTH(64), .BLOCK_BITS(512), .TAG_WIDTH(13)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus_if)
  );

  function automatic logic [511:0] exp_block(input logic [63:0] base);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < int'(BEATS); k++) b[64*k +: 64] = base + 64'(k);
    return b;
  endfunction

  task automatic clear_inputs();
    bus_if.up_reqcyc   = '0;
    bus_if.up_req      = '0;
    bus_if.up_reqtag   = '0;
    bus_if.up_respack  = '0;
    bus_if.bus_reqack  = 1'b0;
    bus_if.bus_respcyc = 1'b0;
    bus_if.bus_resp    = '0;
    bus_if.bus_resptag = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_req(input int port, input logic [63:0] addr, input tag_t tag,
                          output bit acked);
    bus_if.up_req[port]    = addr;
    bus_if.up_reqtag[port] = tag;
    bus_if.up_reqcyc[port] = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (bus_if.up_reqack[port]) acked = 1'b1;
    end
    bus_if.up_reqcyc[port] = 1'b0;
  endtask

  // Waits for bus_reqcyc, holds off bus_reqack for 'delay' cycles, then
  // streams BEATS beats of base+k. Returns on the edge where DELIVER begins.
  task automatic serve_bus(input int delay, input logic [63:0] base,
                           output int held, output bit ok);
    ok   = 1'b1;
    held = 0;
    for (int i = 0; i < 20 && !bus_if.bus_reqcyc; i++) @(negedge clk);
    if (!bus_if.bus_reqcyc) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < delay; i++) begin
      if (bus_if.bus_reqcyc) held++;
      @(negedge clk);
    end
    if (bus_if.bus_reqcyc) held++;
    bus_if.bus_reqack = 1'b1;
    @(negedge clk);
    bus_if.bus_reqack = 1'b0;
    if (bus_if.bus_reqcyc) ok = 1'b0;
    for (int k = 0; k < int'(BEATS); k++) begin
      bus_if.bus_respcyc = 1'b1;
      bus_if.bus_resp    = base + 64'(k);
      #1;
      if (bus_if.bus_respack !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    bus_if.bus_respcyc = 1'b0;
  endtask

  task automatic ack_resp(input int port);
    bus_if.up_respack[port] = 1'b1;
    @(negedge clk);
    bus_if.up_respack[port] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.up_reqack, bus_if.up_respcyc, bus_if.bus_reqcyc} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus_if.up_reqack, bus_if.up_respcyc, bus_if.bus_reqcyc});
    end
    checks++;
    if ({bus_if.bus_req, bus_if.bus_reqtag, bus_if.up_resptag} !== '0) begin
      errors++;
      $display("FAIL reset_bus_fields: got req %h tag %h resptag %h expected 0",
               bus_if.bus_req, bus_if.bus_reqtag, bus_if.up_resptag);
    end
    checks++;
    if (bus_if.up_resp !== '0) begin
      errors++;
      $display("FAIL reset_up_resp: got %h expected 0", bus_if.up_resp);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fill();
    bit acked, ok;
    int held;
    do_reset();
    send_req(0, 64'h1040, tag_t'(5), acked);
    checks++;
    if (!acked || bus_if.up_reqack !== 2'b01) begin
      errors++;
      $display("FAIL single_ack: got acked=%0d reqack=%b expected 1 01", acked, bus_if.up_reqack);
    end
    checks++;
    if (bus_if.bus_reqcyc !== 1'b1 || bus_if.bus_req !== 64'h1040 || bus_if.bus_reqtag !== 13'd5) begin
      errors++;
      $display("FAIL single_bus_req: got cyc=%b addr=%h tag=%0d expected 1 1040 5",
               bus_if.bus_reqcyc, bus_if.bus_req, bus_if.bus_reqtag);
    end
    serve_bus(0, 64'h0, held, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_bus_handshake: got ok=0 expected ok=1");
    end
    checks++;
    if (bus_if.up_respcyc !== 2'b01 || bus_if.up_resptag !== 13'd5) begin
      errors++;
      $display("FAIL single_resp_ctrl: got respcyc=%b tag=%0d expected 01 5",
               bus_if.up_respcyc, bus_if.up_resptag);
    end
    checks++;
    if (bus_if.up_resp !== exp_block(64'h0)) begin
      errors++;
      $display("FAIL single_resp_data: got %h expected %h", bus_if.up_resp, exp_block(64'h0));
    end
    ack_resp(0);
    checks++;
    if (bus_if.up_respcyc !== 2'b00) begin
      errors++;
      $display("FAIL single_resp_drop: got %b expected 00", bus_if.up_respcyc);
    end
  endtask

  task automatic test_unaligned();
    bit acked, ok;
    int held;
    send_req(1, 64'h107F, tag_t'(9), acked);
    checks++;
    if (!acked || bus_if.bus_req !== 64'h1040 || bus_if.bus_reqtag !== 13'd9) begin
      errors++;
      $display("FAIL unaligned_bus_req: got acked=%0d addr=%h tag=%0d expected 1 1040 9",
               acked, bus_if.bus_req, bus_if.bus_reqtag);
    end
    serve_bus(0, 64'hA000, held, ok);
    checks++;
    if (!ok || bus_if.up_respcyc !== 2'b10 || bus_if.up_resp !== exp_block(64'hA000)) begin
      errors++;
      $display("FAIL unaligned_resp: got ok=%0d respcyc=%b data=%h expected 1 10 %h",
               ok, bus_if.up_respcyc, bus_if.up_resp, exp_block(64'hA000));
    end
    ack_resp(1);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_win;
    logic [63:0] exp_addr;
    bit ok, got;
    int held, winner;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_win = 3'b010;
`else
    exp_win = 3'b111;
`endif
    do_reset();
    for (int r = 0; r < 3; r++) begin
      bus_if.up_req[0]    = 64'h2000;
      bus_if.up_req[1]    = 64'h3000;
      bus_if.up_reqtag[0] = tag_t'(20 + r);
      bus_if.up_reqtag[1] = tag_t'(30 + r);
      bus_if.up_reqcyc    = 2'b11;
      got = 1'b0;
      winner = -1;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus_if.up_reqack != 2'b00) got = 1'b1;
      end
      bus_if.up_reqcyc = 2'b00;
      if (bus_if.up_reqack == 2'b01) winner = 0;
      else if (bus_if.up_reqack == 2'b10) winner = 1;
      exp_addr = exp_win[r] ? 64'h3000 : 64'h2000;
      checks++;
      if (winner !== int'(exp_win[r]) || bus_if.bus_req !== exp_addr) begin
        errors++;
        $display("FAIL contention_round%0d: got reqack=%b addr=%h expected port %0d addr %h",
                 r, bus_if.up_reqack, bus_if.bus_req, exp_win[r], exp_addr);
      end
      serve_bus(0, 64'h100 * (r + 1), held, ok);
      checks++;
      if (!ok || bus_if.up_respcyc !== (2'b01 << exp_win[r])) begin
        errors++;
        $display("FAIL contention_resp%0d: got ok=%0d respcyc=%b expected 1 %b",
                 r, ok, bus_if.up_respcyc, 2'b01 << exp_win[r]);
      end
      ack_resp(int'(exp_win[r]));
    end
  endtask

  task automatic test_deliver_stall();
    bit acked, ok, stable;
    int held;
    do_reset();
    send_req(0, 64'h4000, tag_t'(3), acked);
    serve_bus(0, 64'h300, held, ok);
    bus_if.up_req[1]    = 64'h5000;
    bus_if.up_reqtag[1] = tag_t'(4);
    bus_if.up_reqcyc[1] = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.up_respcyc !== 2'b01 || bus_if.up_resp !== exp_block(64'h300) ||
          bus_if.up_resptag !== 13'd3 || bus_if.up_reqack !== 2'b00) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!acked || !ok || !stable) begin
      errors++;
      $display("FAIL stall_hold: got acked=%0d ok=%0d stable=%0d expected 1 1 1", acked, ok, stable);
    end
    bus_if.up_respack[0] = 1'b1;
    @(negedge clk);
    bus_if.up_respack[0] = 1'b0;
    checks++;
    if (bus_if.up_respcyc !== 2'b00 || bus_if.up_reqack !== 2'b00) begin
      errors++;
      $display("FAIL stall_release: got respcyc=%b reqack=%b expected 00 00",
               bus_if.up_respcyc, bus_if.up_reqack);
    end
    @(negedge clk);
    checks++;
    if (bus_if.up_reqack !== 2'b10 || bus_if.bus_req !== 64'h5000) begin
      errors++;
      $display("FAIL stall_next_grant: got reqack=%b addr=%h expected 10 5000",
               bus_if.up_reqack, bus_if.bus_req);
    end
    bus_if.up_reqcyc[1] = 1'b0;
    serve_bus(0, 64'h500, held, ok);
    ack_resp(1);
  endtask

  task automatic test_reset_mid_collect();
    bit acked, ok, quiet;
    int held;
    do_reset();
    send_req(0, 64'h6000, tag_t'(7), acked);
    bus_if.bus_reqack = 1'b1;
    @(negedge clk);
    bus_if.bus_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_if.bus_respcyc = 1'b1;
      bus_if.bus_resp    = 64'hF0 + 64'(k);
      @(negedge clk);
    end
    bus_if.bus_respcyc = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.up_reqack, bus_if.up_respcyc, bus_if.bus_reqcyc} !== 5'b0 ||
        bus_if.up_resp !== '0 || bus_if.bus_req !== '0 || bus_if.up_resptag !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctrl=%b req=%h resp=%h expected all 0",
               {bus_if.up_reqack, bus_if.up_respcyc, bus_if.bus_reqcyc}, bus_if.bus_req, bus_if.up_resp);
    end
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.up_respcyc !== 2'b00) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL midreset_no_resp: got respcyc activity expected none");
    end
    send_req(1, 64'h7000, tag_t'(11), acked);
    serve_bus(0, 64'h50, held, ok);
    checks++;
    if (!acked || !ok || bus_if.up_respcyc !== 2'b10 || bus_if.up_resptag !== 13'd11 ||
        bus_if.up_resp !== exp_block(64'h50)) begin
      errors++;
      $display("FAIL midreset_recover: got respcyc=%b tag=%0d data=%h expected 10 11 %h",
               bus_if.up_respcyc, bus_if.up_resptag, bus_if.up_resp, exp_block(64'h50));
    end
    ack_resp(1);
  endtask

  task automatic test_bus_wait_and_stray();
    bit acked, ok;
    int held;
    do_reset();
    bus_if.bus_respcyc = 1'b1;
    bus_if.bus_resp    = 64'hDEAD;
    #1;
    checks++;
    if (bus_if.bus_respack !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack: got %b expected 1", bus_if.bus_respack);
    end
    @(negedge clk);
    bus_if.bus_respcyc = 1'b0;
    checks++;
    if (bus_if.up_resp !== '0 || bus_if.up_respcyc !== 2'b00) begin
      errors++;
      $display("FAIL stray_ignored: got respcyc=%b data=%h expected 00 0",
               bus_if.up_respcyc, bus_if.up_resp);
    end
    send_req(0, 64'h8000, tag_t'(1), acked);
    serve_bus(5, 64'h900, held, ok);
    // held counts the 5 wait cycles plus the cycle bus_reqack is presented.
    checks++;
    if (held !== 6 || !ok) begin
      errors++;
      $display("FAIL buswait_hold: got held=%0d ok=%0d expected 6 1", held, ok);
    end
    checks++;
    if (bus_if.up_respcyc !== 2'b01 || bus_if.up_resp !== exp_block(64'h900)) begin
      errors++;
      $display("FAIL buswait_resp: got respcyc=%b data=%h expected 01 %h",
               bus_if.up_respcyc, bus_if.up_resp, exp_block(64'h900));
    end
    ack_resp(0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fill();
    test_unaligned();
    test_back_to_back();
    test_deliver_stall();
    test_reset_mid_collect();
    test_bus_wait_and_stray();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
